// File: rtl/uart_pkg.sv
// Shared UART definitions: rx state encodings, parameter legality bounds and the parity helper.
// Used by the receiver today and intended for the parametrised transmitter.
package uart_pkg;

  localparam int DATA_W_MIN  = 5;
  localparam int DATA_W_MAX  = 9;
  localparam int OS_RATE_MIN = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

  // Expected parity bit for a zero-extended data word.
  function automatic logic parity_expected(input logic [DATA_W_MAX-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability chain for the serial line; SYNC_STAGES clk latency, idles high out of reset.
// No backpressure: free-running flop chain.
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rx_s
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver; word appears OS_RATE/2 + OS_RATE*(DATA_W+P+S) os_ticks after start detect.
// Output held until rx_ready; a word completing while the held word is unaccepted is dropped and flagged.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int OS_RATE     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              os_tick,
  input  logic              rx_i,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              two_stop,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun_err,
  output logic              busy
);

  localparam int OS_W = $clog2(OS_RATE);
  localparam int BC_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  localparam logic [OS_W-1:0] HALF_M1  = OS_W'(OS_RATE/2 - 1);
  localparam logic [OS_W-1:0] FULL_M1  = OS_W'(OS_RATE - 1);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_W - 1);

  logic                  rx_s;
  logic [2:0]            state;
  logic [OS_W-1:0]       os_cnt;
  logic [BC_W-1:0]       bit_cnt;
  logic [DATA_W-1:0]     shreg;
  logic                  par_en_q;
  logic                  par_odd_q;
  logic                  two_stop_q;
  logic                  par_flag;
  logic                  frame_acc;
  logic [DATA_W_MAX-1:0] data_ext;
  logic                  load_ok;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .rx_i (rx_i),
    .rx_s (rx_s)
  );

  always_comb begin
    data_ext = '0;
    data_ext[DATA_W-1:0] = shreg;
  end

  // A completing word may be stored if the slot is empty or being drained on the same edge.
  assign load_ok = !rx_valid || rx_ready;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      os_cnt      <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      two_stop_q  <= 1'b0;
      par_flag    <= 1'b0;
      frame_acc   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
      if (os_tick) begin
        case (state)
          ST_IDLE: begin
            if (!rx_s) begin
              state      <= ST_START;
              os_cnt     <= '0;
              bit_cnt    <= '0;
              par_flag   <= 1'b0;
              frame_acc  <= 1'b0;
              par_en_q   <= parity_en;
              par_odd_q  <= parity_odd;
              two_stop_q <= two_stop;
            end
          end
          ST_START: begin
            if (os_cnt == HALF_M1) begin
              os_cnt <= '0;
              state  <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (os_cnt == FULL_M1) begin
              os_cnt <= '0;
              shreg  <= {rx_s, shreg[DATA_W-1:1]};
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                state   <= par_en_q ? ST_PARITY : ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
          ST_PARITY: begin
            if (os_cnt == FULL_M1) begin
              os_cnt   <= '0;
              par_flag <= (rx_s != parity_expected(data_ext, par_odd_q));
              state    <= ST_STOP;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
          ST_STOP: begin
            if (os_cnt == FULL_M1) begin
              os_cnt <= '0;
              if (two_stop_q && (bit_cnt == '0)) begin
                bit_cnt <= BC_W'(1);
                if (!rx_s) frame_acc <= 1'b1;
              end else begin
                // Final stop sample: deliver the word or report it as dropped.
                if (load_ok) begin
                  rx_data    <= shreg;
                  parity_err <= par_flag;
                  frame_err  <= frame_acc | ~rx_s;
                  rx_valid   <= 1'b1;
                end else begin
                  overrun_err <= 1'b1;
                end
                state <= rx_s ? ST_IDLE : ST_WAIT_HIGH;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
          ST_WAIT_HIGH: begin
            if (rx_s) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: an 8-bit instance for most frames, a 7-bit instance for 7O2.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       os_tick = 1'b1;
  logic       rx_i = 1'b1;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       two_stop = 1'b0;
  logic       rx_ready = 1'b1;

  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun_err, busy;
  logic [6:0] rx_data7;
  logic       rx_valid7, parity_err7, frame_err7, overrun_err7, busy7;

  int pass_cnt = 0;
  int total_cnt = 0;

  int         word_cnt = 0, ovr_cnt = 0, word_cnt7 = 0, ovr_cnt7 = 0;
  logic [7:0] last_data = '0;
  logic       last_perr = 1'b0, last_ferr = 1'b0;
  logic [6:0] last_data7 = '0;
  logic       last_perr7 = 1'b0, last_ferr7 = 1'b0;

  always #5 clk = ~clk;

  uart_rx_core #(.DATA_W(8), .OS_RATE(16), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .os_tick(os_tick), .rx_i(rx_i),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err), .busy(busy)
  );

  uart_rx_core #(.DATA_W(7), .OS_RATE(16), .SYNC_STAGES(2)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .os_tick(os_tick), .rx_i(rx_i),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .rx_data(rx_data7), .rx_valid(rx_valid7), .rx_ready(rx_ready),
    .parity_err(parity_err7), .frame_err(frame_err7), .overrun_err(overrun_err7), .busy(busy7)
  );

  // Accepted words and overrun pulses, observed on the falling edge.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      word_cnt++; last_data = rx_data; last_perr = parity_err; last_ferr = frame_err;
    end
    if (overrun_err) ovr_cnt++;
    if (rx_valid7 && rx_ready) begin
      word_cnt7++; last_data7 = rx_data7; last_perr7 = parity_err7; last_ferr7 = frame_err7;
    end
    if (overrun_err7) ovr_cnt7++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [8:0] d, input int nbits, input logic pen,
                            input logic pbit, input int nstop, input logic last_stop);
    @(posedge clk); #1;
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    if (nstop == 2) drive_bit(1'b1);
    drive_bit(last_stop);
    rx_i = 1'b1;
  endtask

  task automatic set_mode(input logic pen, input logic podd, input logic two);
    parity_en = pen; parity_odd = podd; two_stop = two;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       podd;
    logic       pbit;
    logic       two;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int w0, o0;
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0};
    vecs[2] = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};
    vecs[5] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[6] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1};
    vecs[7] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[8] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[9] = '{8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h96, 1'b0, 1'b1};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'b0, rx_valid}, 32'd0);
    check("rst_data", {24'b0, rx_data}, 32'd0);
    check("rst_perr", {31'b0, parity_err}, 32'd0);
    check("rst_ferr", {31'b0, frame_err}, 32'd0);
    check("rst_ovr", {31'b0, overrun_err}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_busy7", {31'b0, busy7}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Completion latency: start detected 3 edges after the line falls, word 152 ticks later
    set_mode(1'b0, 1'b0, 1'b0);
    fork
      send_frame(9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        @(negedge clk);
        check("lat_before", {31'b0, rx_valid}, 32'd0);
        @(posedge clk); @(negedge clk);
        check("lat_at152", {31'b0, rx_valid}, 32'd1);
        check("lat_data", {24'b0, rx_data}, 32'hA5);
      end
    join
    repeat (20) @(posedge clk);

    // Frame table
    for (int v = 0; v < 10; v++) begin
      w0 = word_cnt;
      set_mode(vecs[v].pen, vecs[v].podd, vecs[v].two);
      send_frame({1'b0, vecs[v].data}, 8, vecs[v].pen, vecs[v].pbit,
                 vecs[v].two ? 2 : 1, vecs[v].stop);
      repeat (20) @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_count", v), word_cnt - w0, 32'd1);
      check($sformatf("vec%0d_data", v), {24'b0, last_data}, {24'b0, vecs[v].exp_data});
      check($sformatf("vec%0d_perr", v), {31'b0, last_perr}, {31'b0, vecs[v].exp_perr});
      check($sformatf("vec%0d_ferr", v), {31'b0, last_ferr}, {31'b0, vecs[v].exp_ferr});
    end

    // Glitch shorter than half a bit
    set_mode(1'b0, 1'b0, 1'b0);
    w0 = word_cnt;
    @(posedge clk); #1 rx_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("glitch_busy_mid", {31'b0, busy}, 32'd1);
    @(posedge clk); #1 rx_i = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("glitch_busy_end", {31'b0, busy}, 32'd0);
    check("glitch_no_word", word_cnt - w0, 32'd0);

    // Break: line low through the frame and 40 ticks beyond
    w0 = word_cnt;
    @(posedge clk); #1 rx_i = 1'b0;
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("break_wait_busy", {31'b0, busy}, 32'd1);
    check("break_one_word_low", word_cnt - w0, 32'd1);
    @(posedge clk); #1 rx_i = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("break_one_word", word_cnt - w0, 32'd1);
    check("break_data", {24'b0, last_data}, 32'h00);
    check("break_ferr", {31'b0, last_ferr}, 32'd1);
    check("break_idle", {31'b0, busy}, 32'd0);
    w0 = word_cnt;
    send_frame(9'h05A, 8, 1'b0, 1'b0, 1, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("after_break_count", word_cnt - w0, 32'd1);
    check("after_break_data", {24'b0, last_data}, 32'h5A);
    check("after_break_ferr", {31'b0, last_ferr}, 32'd0);

    // Overrun with consumer stalled
    w0 = word_cnt; o0 = ovr_cnt;
    @(posedge clk); #1 rx_ready = 1'b0;
    send_frame(9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
    repeat (20) @(posedge clk);
    send_frame(9'h022, 8, 1'b0, 1'b0, 1, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("ovr_valid_held", {31'b0, rx_valid}, 32'd1);
    check("ovr_data_kept", {24'b0, rx_data}, 32'h11);
    check("ovr_pulse_once", ovr_cnt - o0, 32'd1);
    @(posedge clk); #1 rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ovr_accept_count", word_cnt - w0, 32'd1);
    check("ovr_accept_data", {24'b0, last_data}, 32'h11);
    check("ovr_valid_clear", {31'b0, rx_valid}, 32'd0);

    // Reset mid-frame at tick 60 of a 0xFF frame
    fork
      send_frame(9'h0FF, 8, 1'b0, 1'b0, 1, 1'b1);
      begin
        @(posedge clk);
        repeat (63) @(posedge clk);
        #1;
        check("midrst_busy_before", {31'b0, busy}, 32'd1);
        check("midrst_data_before", {24'b0, rx_data}, 32'h11);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_data", {24'b0, rx_data}, 32'd0);
        check("midrst_valid", {31'b0, rx_valid}, 32'd0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    join
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("midrst_no_word", {31'b0, rx_valid}, 32'd0);

    // 7O2 0x7F on the 7-bit instance: seven ones, odd parity bit is 0
    w0 = word_cnt7;
    set_mode(1'b1, 1'b1, 1'b1);
    send_frame(9'h07F, 7, 1'b1, 1'b0, 2, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("o72_count", word_cnt7 - w0, 32'd1);
    check("o72_data", {25'b0, last_data7}, 32'h7F);
    check("o72_perr", {31'b0, last_perr7}, 32'd0);
    check("o72_ferr", {31'b0, last_ferr7}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
